// File: rtl/vga_sram_reader.sv
// vga_sram_reader: 32-bit read-only bridge from a frame-fetch master to a
// 16-bit asynchronous SRAM, built from two half-word accesses per request.
// Optional speculative next-word prefetch is enabled by defining
// VGA_SRAM_READER_PREFETCH_EN; the default build has no prefetch logic.
module vga_sram_reader #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        avs_read,
  input  logic [31:0] avs_address,
  output logic        avs_waitrequest,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic [17:0] sram_addr,
  input  logic [15:0] sram_dq_in,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam int unsigned WORD_W = 17;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI
`ifdef VGA_SRAM_READER_PREFETCH_EN
    ,
    PF_LO,
    PF_HI
`endif
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] word;
  logic [15:0]       lo_buf;
  logic              strobe_n;
  logic              accept;
  logic [WORD_W-1:0] req_word;
  logic              unused_addr;

  assign accept      = avs_read && !avs_waitrequest;
  assign req_word    = avs_address[18:2];
  assign unused_addr = ^{avs_address[31:19], avs_address[1:0]};

  // One shared active-low enable covers chip, output and both byte lanes
  assign sram_ce_n = strobe_n;
  assign sram_oe_n = strobe_n;
  assign sram_ub_n = strobe_n;
  assign sram_lb_n = strobe_n;
  assign sram_we_n = 1'b1;

`ifdef VGA_SRAM_READER_PREFETCH_EN
  logic [31:0]       pf_data;
  logic [WORD_W-1:0] pf_addr;
  logic              pf_valid;
  logic              pf_pending;
  logic              pf_hit;
  logic [WORD_W-1:0] next_word;

  assign pf_hit    = pf_valid && (req_word == pf_addr);
  assign next_word = word + WORD_W'(1);
`endif

  // Access sequencer: accept, low half window, high half window, return
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      cnt               <= '0;
      word              <= '0;
      lo_buf            <= '0;
      strobe_n          <= 1'b1;
      sram_addr         <= '0;
      avs_waitrequest   <= 1'b1;
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= '0;
`ifdef VGA_SRAM_READER_PREFETCH_EN
      pf_data           <= '0;
      pf_addr           <= '0;
      pf_valid          <= 1'b0;
      pf_pending        <= 1'b0;
`endif
    end else begin
      avs_readdatavalid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            word <= req_word;
`ifdef VGA_SRAM_READER_PREFETCH_EN
            pf_pending <= pf_hit;
            if (!pf_hit) pf_valid <= 1'b0;
            // A hit returns the buffered word next cycle and stays ready
            if (pf_hit) begin
              avs_readdata      <= pf_data;
              avs_readdatavalid <= 1'b1;
            end else
`endif
            begin
              state           <= LO;
              cnt             <= CNT_LAST;
              sram_addr       <= {req_word, 1'b0};
              strobe_n        <= 1'b0;
              avs_waitrequest <= 1'b1;
            end
          end else begin
            avs_waitrequest <= 1'b0;
`ifdef VGA_SRAM_READER_PREFETCH_EN
            // Nothing accepted after a returned word: fetch the next one
            if (pf_pending) begin
              pf_pending      <= 1'b0;
              pf_valid        <= 1'b0;
              pf_addr         <= next_word;
              state           <= PF_LO;
              cnt             <= CNT_LAST;
              sram_addr       <= {next_word, 1'b0};
              strobe_n        <= 1'b0;
              avs_waitrequest <= 1'b1;
            end
`endif
          end
        end
        LO: begin
          if (cnt == '0) begin
            lo_buf    <= sram_dq_in;
            state     <= HI;
            cnt       <= CNT_LAST;
            sram_addr <= {word, 1'b1};
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HI: begin
          if (cnt == '0) begin
            avs_readdata      <= {sram_dq_in, lo_buf};
            avs_readdatavalid <= 1'b1;
            avs_waitrequest   <= 1'b0;
            strobe_n          <= 1'b1;
            state             <= IDLE;
`ifdef VGA_SRAM_READER_PREFETCH_EN
            pf_pending        <= 1'b1;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`ifdef VGA_SRAM_READER_PREFETCH_EN
        PF_LO: begin
          if (cnt == '0) begin
            pf_data[15:0] <= sram_dq_in;
            state         <= PF_HI;
            cnt           <= CNT_LAST;
            sram_addr     <= {pf_addr, 1'b1};
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        PF_HI: begin
          if (cnt == '0) begin
            pf_data[31:16]  <= sram_dq_in;
            pf_valid        <= 1'b1;
            strobe_n        <= 1'b1;
            avs_waitrequest <= 1'b0;
            state           <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sram_reader.sv
// tb_vga_sram_reader: directed table, hand-written corner sequences and
// random traffic against a cycle-count reference model of the reader.
module tb_vga_sram_reader;

  localparam int W = 2;

  logic        clk;
  logic        reset_n;
  logic        avs_read;
  logic [31:0] avs_address;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_in;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  logic [15:0] mem [0:262143];
  assign sram_dq_in = mem[sram_addr];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b1;

  vga_sram_reader #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_read(avs_read), .avs_address(avs_address),
    .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .sram_addr(sram_addr), .sram_dq_in(sram_dq_in),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a request occupies 2*W cycles after acceptance, data
  // appears in the following cycle, then the reader is ready again.
  bit          m_first, m_busy, m_done;
  int          m_k;
  logic [16:0] m_word;
  logic [31:0] m_data;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_first = 1'b1; m_busy = 1'b0; m_done = 1'b0;
      m_k = 0; m_word = '0; m_data = '0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_k++;
        if (m_k == 2 * W) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_data = {mem[{m_word, 1'b1}], mem[{m_word, 1'b0}]};
        end
      end else if (m_first) begin
        m_first = 1'b0;
      end else if (avs_read) begin
        m_busy = 1'b1;
        m_k    = 0;
        m_word = avs_address[18:2];
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (mon_en) begin
      if (!reset_n) begin
        check("rst_wait", 32'(avs_waitrequest), 32'd1);
        check("rst_valid", 32'(avs_readdatavalid), 32'd0);
        check("rst_data", avs_readdata, 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_we_n}), 32'h1F);
      end else begin
        check("mon_wait", 32'(avs_waitrequest), 32'(m_first || m_busy));
        check("mon_valid", 32'(avs_readdatavalid), 32'(m_done));
        check("mon_data", avs_readdata, m_data);
        check("mon_strobes", 32'({sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_we_n}),
              m_busy ? 32'h01 : 32'h1F);
        if (m_busy)
          check("mon_addr", 32'(sram_addr), 32'({m_word, (m_k >= W) ? 1'b1 : 1'b0}));
      end
    end
  end

  // Single read with explicit latency, address and data checks
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [17:0] exp_lo, input int exp_lat, input string nm);
    int n;
    bit seen;
    @(negedge clk);
    n = 0;
    while (avs_waitrequest && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_ready"}, 32'(avs_waitrequest), 32'd0);
    avs_read    = 1'b1;
    avs_address = addr;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        avs_read    = 1'b0;
        avs_address = $urandom;
        if (exp_lat > 1) begin
          check({nm, "_lo_addr"}, 32'(sram_addr), 32'(exp_lo));
          check({nm, "_ce_lo"}, 32'(sram_ce_n), 32'd0);
        end else begin
          check({nm, "_ce_hit"}, 32'(sram_ce_n), 32'd1);
        end
      end
      if (n == W + 1 && exp_lat > 1)
        check({nm, "_hi_addr"}, 32'(sram_addr), 32'(exp_lo | 18'd1));
      seen = avs_readdatavalid;
    end
    check({nm, "_latency"}, 32'(n), 32'(exp_lat));
    check({nm, "_data"}, avs_readdata, exp_data);
    @(negedge clk);
    check({nm, "_onecycle"}, 32'(avs_readdatavalid), 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic [17:0] exp_lo;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    reset_n     = 1'b0;
    avs_read    = 1'b0;
    avs_address = '0;
    for (int i = 0; i < 262144; i++) mem[i] = 16'($urandom);
    mem[8]       = 16'h1234;  mem[9]       = 16'hABCD;
    mem[18'h3FFFE] = 16'h5555; mem[18'h3FFFF] = 16'h6666;
    mem[0]       = 16'h0F0F;  mem[1]       = 16'hF0F0;
    mem[18'h80]  = 16'h2222;  mem[18'h81]  = 16'h3333;
    mem[18'h82]  = 16'h4444;  mem[18'h83]  = 16'h5555;
    mem[18'h100] = 16'h7777;  mem[18'h101] = 16'h8888;

    tbl[0] = '{32'h0000_0010, 32'hABCD_1234, 18'h00008};
    tbl[1] = '{32'h0007_FFFC, 32'h6666_5555, 18'h3FFFE};
    tbl[2] = '{32'h0008_0000, 32'hF0F0_0F0F, 18'h00000};
    tbl[3] = '{32'hABC0_0010, 32'hABCD_1234, 18'h00008};
    tbl[4] = '{32'hFFFF_FFFF, 32'h6666_5555, 18'h3FFFE};
    tbl[5] = '{32'h0000_0103, 32'h3333_2222, 18'h00080};

`ifdef VGA_SRAM_READER_PREFETCH_EN
    mon_en = 1'b0;
`endif

    repeat (3) @(negedge clk);
    #1;
    check("init_wait", 32'(avs_waitrequest), 32'd1);
    check("init_strobes", 32'({sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}), 32'hF);
    #1 reset_n = 1'b1;
    #1 check("post_rst_wait_before_edge", 32'(avs_waitrequest), 32'd1);
    @(negedge clk);
    check("post_rst_wait_first_edge", 32'(avs_waitrequest), 32'd0);

`ifdef VGA_SRAM_READER_PREFETCH_EN
    do_read(32'h0000_0100, 32'h3333_2222, 18'h00080, 2 * W + 1, "pf_first");
    repeat (12) @(negedge clk);
    check("pf_idle_wait", 32'(avs_waitrequest), 32'd0);
    check("pf_idle_ce", 32'(sram_ce_n), 32'd1);
    do_read(32'h0000_0104, 32'h5555_4444, 18'h00000, 1, "pf_hit");
    do_read(32'h0000_0200, 32'h8888_7777, 18'h00100, 2 * W + 1, "pf_miss");
`else
    for (int i = 0; i < 6; i++)
      do_read(tbl[i].addr, tbl[i].exp_data, tbl[i].exp_lo, 2 * W + 1, $sformatf("tbl%0d", i));

    // Back-to-back reads with avs_read held high
    begin
      int w;
      @(negedge clk);
      avs_read    = 1'b1;
      avs_address = 32'h0;
      for (int c = 1; c <= 15; c++) begin
        @(negedge clk);
        check($sformatf("b2b_valid_c%0d", c), 32'(avs_readdatavalid), 32'(c % 5 == 0));
        check($sformatf("b2b_wait_c%0d", c), 32'(avs_waitrequest), 32'(c % 5 != 0));
        if (c % 5 == 0) begin
          w = c / 5 - 1;
          check($sformatf("b2b_data_c%0d", c), avs_readdata, {mem[2 * w + 1], mem[2 * w]});
          avs_address = avs_address + 32'd4;
          if (c == 15) avs_read = 1'b0;
        end
      end
    end

    // Reset asserted during the high half-word window
    @(negedge clk);
    avs_read    = 1'b1;
    avs_address = 32'h0000_0010;
    @(negedge clk);
    avs_read = 1'b0;
    repeat (W) @(negedge clk);
    check("abort_in_hi", 32'(sram_addr), 32'h9);
    #2 reset_n = 1'b0;
    #1;
    check("abort_strobes", 32'({sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}), 32'hF);
    check("abort_wait", 32'(avs_waitrequest), 32'd1);
    check("abort_valid", 32'(avs_readdatavalid), 32'd0);
    check("abort_data", avs_readdata, 32'd0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (6) @(negedge clk);
    do_read(32'h0000_0010, 32'hABCD_1234, 18'h00008, 2 * W + 1, "after_abort");

    // Random traffic, including requests dropped mid-access
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      avs_read = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: avs_address = 32'h0007_FFFC;
        1: avs_address = {$urandom_range(0, 15), 28'h000_0000} | 32'($urandom_range(0, 64));
        default: avs_address = $urandom;
      endcase
    end
    avs_read = 1'b0;
    repeat (10) @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
